// File: rtl/hazard_sched_pp.sv
// Hazard scheduler for the 5-stage core: same-cycle advance/stall/flush decisions and EX forwarding selects.
// Control outputs are combinational on the current stage contents; stall/flush statistics update on the next edge.
module hazard_sched_pp #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_forwarding,
  input  logic [RA_W-1:0]  rs_id,
  input  logic [RA_W-1:0]  rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic             jump_id,
  input  logic [RA_W-1:0]  rs_ex,
  input  logic [RA_W-1:0]  rt_ex,
  input  logic [RA_W-1:0]  rd_ex,
  input  logic             regwrite_ex,
  input  logic             memread_ex,
  input  logic             branch_taken_ex,
  input  logic [RA_W-1:0]  rd_mem,
  input  logic             regwrite_mem,
  input  logic [RA_W-1:0]  rd_wb,
  input  logic             regwrite_wb,
  output logic             pc_write,
  output logic             we_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic {RUN, STALL} state_t;

  typedef struct packed {
    logic ex;
    logic mem;
    logic wb;
  } hit_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       mode_q, mode_d;
  logic       mode_eff;
  hit_t       id_hit;
  logic       load_use;
  logic [1:0] stall_len;
  logic       stall;
  logic       pc_write_raw, we_if_id_raw, flush_if_id_raw, flush_id_ex_raw;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // Register 0 is hardwired, so a write to it never produces a dependency.
  function automatic logic match(input logic we, input logic [RA_W-1:0] rd,
                                 input logic [RA_W-1:0] r);
    return we && (rd != '0) && (rd == r);
  endfunction

  function automatic logic id_match(input logic we, input logic [RA_W-1:0] rd);
    return (use_rs_id && match(we, rd, rs_id)) || (use_rt_id && match(we, rd, rt_id));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] r);
    if (match(regwrite_mem, rd_mem, r))     return 2'b10;
    else if (match(regwrite_wb, rd_wb, r))  return 2'b01;
    else                                    return 2'b00;
  endfunction

  always_comb begin
    id_hit.ex  = id_match(regwrite_ex, rd_ex);
    id_hit.mem = id_match(regwrite_mem, rd_mem);
    id_hit.wb  = id_match(regwrite_wb, rd_wb);
    load_use   = memread_ex && id_hit.ex;
    if (id_hit.ex)       stall_len = 2'd3;
    else if (id_hit.mem) stall_len = 2'd2;
    else if (id_hit.wb)  stall_len = 2'd1;
    else                 stall_len = 2'd0;
  end

  // Mode is frozen while stalling so a mid-stall mode flip cannot change the stall length or selects.
  assign mode_eff = (state_q == RUN) ? enable_forwarding : mode_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    mode_d          = mode_q;
    stall           = 1'b0;
    pc_write_raw    = 1'b1;
    we_if_id_raw    = 1'b1;
    flush_if_id_raw = 1'b0;
    flush_id_ex_raw = 1'b0;
    if (state_q == RUN) mode_d = enable_forwarding;
    if (branch_taken_ex) begin
      flush_if_id_raw = 1'b1;
      flush_id_ex_raw = 1'b1;
      state_d         = RUN;
      cnt_d           = 2'd0;
    end else begin
      if (state_q == STALL) begin
        stall = 1'b1;
        if (cnt_q == 2'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 2'd1;
      end else if (enable_forwarding) begin
        stall = load_use;
      end else if (stall_len != 2'd0) begin
        stall = 1'b1;
        if (stall_len > 2'd1) begin
          state_d = STALL;
          cnt_d   = stall_len - 2'd2;
        end
      end
      // A held jump is redirected only once ID is allowed to advance.
      if (stall) begin
        pc_write_raw    = 1'b0;
        we_if_id_raw    = 1'b0;
        flush_id_ex_raw = 1'b1;
      end else if (jump_id) begin
        flush_if_id_raw = 1'b1;
      end
    end
  end

  assign fwd_a_raw = mode_eff ? fwd_sel(rs_ex) : 2'b00;
  assign fwd_b_raw = mode_eff ? fwd_sel(rt_ex) : 2'b00;

  always_comb begin
    pc_write    = 1'b1;
    we_if_id    = 1'b1;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (rst) begin
      pc_write    = pc_write_raw;
      we_if_id    = we_if_id_raw;
      flush_if_id = flush_if_id_raw;
      flush_id_ex = flush_id_ex_raw;
      fwd_a       = fwd_a_raw;
      fwd_b       = fwd_b_raw;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_write && (stall_cycles != '1))   stall_cycles <= stall_cycles + CNT_ONE;
      if (flush_if_id && (flush_events != '1)) flush_events <= flush_events + CNT_ONE;
    end
  end

endmodule
